button_blink_stretcher: RTL and testbench

// - Inverse of the button pulser: turns single-cycle event pulses into human-visible LED blinks.
// - Each accepted pulse produces exactly one blink: ON_CYCLES high, then GAP_CYCLES low.
// - Pulses arriving during a blink are queued in a saturating pending counter, so no event merges into another.
// - Sits between pulser or event sources and board LEDs as a status indicator for button and frame events.

---
 rtl/button_blink_stretcher_pkg.sv | 20 ++
 rtl/button_blink_stretcher_timer.sv | 28 ++
 rtl/button_blink_stretcher.sv | 129 ++++++++++++
 tb/tb_button_blink_stretcher.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_blink_stretcher_pkg.sv
// Shared types and board defaults for the LED blink stretcher.
package blink_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    IDLE  = 2'd1,
    ON    = 2'd2,
    GAP   = 2'd3
  } blink_state_t;

  // Board defaults: 25 MHz clock gives a 1 s blink followed by a 0.5 s gap.
  localparam int unsigned BOARD_ON_CYCLES  = 25_000_000;
  localparam int unsigned BOARD_GAP_CYCLES = 12_500_000;
  localparam int unsigned BOARD_PEND_W     = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_blink_stretcher_timer.sv
// Loadable down-counter shared by the ON and GAP phases; saturates at zero.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Load has priority over counting; counting stops at zero so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/button_blink_stretcher.sv
// Turns single-cycle event pulses into one visible LED blink each, queueing
// events that arrive while a blink is in progress.
module button_blink_stretcher
  import blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = BOARD_ON_CYCLES,
  parameter int unsigned GAP_CYCLES = BOARD_GAP_CYCLES,
  parameter int unsigned PEND_W     = BOARD_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              clr_ovf,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int unsigned       TW       = $clog2(max_u(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_t      r_state;
  logic [PEND_W-1:0] r_pending;
  logic              r_ovf;

  logic              w_pend_nz;
  logic              w_tmr_zero;
  logic              w_start;
  logic              w_load;
  logic              w_en;
  logic [TW-1:0]     w_load_val;
  logic              w_drop;

  assign w_pend_nz = (r_pending != '0);

  cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .zero     (w_tmr_zero)
  );

  // Timer control and blink-start strobe, decoded from the current state.
  always_comb begin
    w_start    = 1'b0;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (w_pend_nz) begin
          w_start    = 1'b1;
          w_load     = 1'b1;
          w_load_val = ON_LOAD;
        end
      end
      ON: begin
        if (w_tmr_zero) begin
          w_load     = 1'b1;
          w_load_val = GAP_LOAD;
        end else begin
          w_en = 1'b1;
        end
      end
      GAP: begin
        if (w_tmr_zero) begin
          if (w_pend_nz) begin
            w_start    = 1'b1;
            w_load     = 1'b1;
            w_load_val = ON_LOAD;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Blink sequencer: RESET -> IDLE -> ON -> GAP -> (ON | IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET;
    end else begin
      case (r_state)
        RESET: r_state <= IDLE;
        IDLE:  if (w_pend_nz) r_state <= ON;
        ON:    if (w_tmr_zero) r_state <= GAP;
        GAP:   if (w_tmr_zero) r_state <= w_pend_nz ? ON : IDLE;
        default: r_state <= RESET;
      endcase
    end
  end

  // An event is lost only when it arrives at saturation with no blink starting.
  assign w_drop = din && !w_start && (r_pending == PEND_MAX);

  // Pending-event queue depth and sticky overflow flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case ({din, w_start})
        2'b10:   if (!w_drop) r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: ;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign dout    = (r_state == ON);
  assign busy    = (r_state == ON) || (r_state == GAP) || w_pend_nz;
  assign pending = r_pending;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_button_blink_stretcher.sv
// Directed bench for button_blink_stretcher with ON=4, GAP=2, PEND_W=2.
module tb_button_blink_stretcher;

  logic       clk = 1'b1;
  logic       rst;
  logic       din;
  logic       clr_ovf;
  logic       dout;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  button_blink_stretcher #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .clr_ovf (clr_ovf),
    .dout    (dout),
    .busy    (busy),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         s;
    int         lo;
    int         hi;
    logic       chk;
    logic       rst;
    logic       din;
    logic       clr;
    logic       dout;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t  vq[$];
  string names[5] = '{"single", "burst", "overflow", "setwins", "rstmid"};
  int    exp_blinks[5] = '{1, 3, 4, 1, 1};

  task automatic seg(input int s, input int lo, input int hi, input logic chk,
                     input logic r, input logic d, input logic c, input logic o_d,
                     input logic o_b, input logic [1:0] o_p, input logic o_v);
    vec_t v;
    v.s = s; v.lo = lo; v.hi = hi; v.chk = chk; v.rst = r; v.din = d; v.clr = c;
    v.dout = o_d; v.busy = o_b; v.pend = o_p; v.ovf = o_v;
    vq.push_back(v);
  endtask

  // Reset held for cycles 0-2 with din high, then quiet idle until cycle 9.
  task automatic prefix(input int s);
    seg(s, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    seg(s, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    seg(s, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input logic r, input logic d, input logic c);
    rst = r; din = d; clr_ovf = c;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int cyc, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got dout/busy/pend/ovf=%b_%b_%0d_%b required %b_%b_%0d_%b",
               nm, cyc, got[4], got[3], got[2:1], got[0], exp[4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; clr_ovf = 1'b0;

    // single event in cycle 10
    prefix(0);
    seg(0, 10, 10, 1, 0, 1, 0, 0, 0, 0, 0);
    seg(0, 11, 11, 1, 0, 0, 0, 0, 1, 1, 0);
    seg(0, 12, 15, 1, 0, 0, 0, 1, 1, 0, 0);
    seg(0, 16, 17, 1, 0, 0, 0, 0, 1, 0, 0);
    seg(0, 18, 20, 1, 0, 0, 0, 0, 0, 0, 0);

    // burst in cycles 10-12
    prefix(1);
    seg(1, 10, 10, 1, 0, 1, 0, 0, 0, 0, 0);
    seg(1, 11, 11, 1, 0, 1, 0, 0, 1, 1, 0);
    seg(1, 12, 12, 1, 0, 1, 0, 1, 1, 1, 0);
    seg(1, 13, 15, 1, 0, 0, 0, 1, 1, 2, 0);
    seg(1, 16, 17, 1, 0, 0, 0, 0, 1, 2, 0);
    seg(1, 18, 21, 1, 0, 0, 0, 1, 1, 1, 0);
    seg(1, 22, 23, 1, 0, 0, 0, 0, 1, 1, 0);
    seg(1, 24, 27, 1, 0, 0, 0, 1, 1, 0, 0);
    seg(1, 28, 29, 1, 0, 0, 0, 0, 1, 0, 0);
    seg(1, 30, 31, 1, 0, 0, 0, 0, 0, 0, 0);

    // overflow: din 10-14, cycle-14 event dropped, clr_ovf in cycle 20
    prefix(2);
    seg(2, 10, 10, 1, 0, 1, 0, 0, 0, 0, 0);
    seg(2, 11, 11, 1, 0, 1, 0, 0, 1, 1, 0);
    seg(2, 12, 12, 1, 0, 1, 0, 1, 1, 1, 0);
    seg(2, 13, 13, 1, 0, 1, 0, 1, 1, 2, 0);
    seg(2, 14, 14, 1, 0, 1, 0, 1, 1, 3, 0);
    seg(2, 15, 15, 1, 0, 0, 0, 1, 1, 3, 1);
    seg(2, 16, 17, 1, 0, 0, 0, 0, 1, 3, 1);
    seg(2, 18, 19, 1, 0, 0, 0, 1, 1, 2, 1);
    seg(2, 20, 20, 1, 0, 0, 1, 1, 1, 2, 1);
    seg(2, 21, 21, 1, 0, 0, 0, 1, 1, 2, 0);
    seg(2, 22, 23, 1, 0, 0, 0, 0, 1, 2, 0);
    seg(2, 24, 27, 1, 0, 0, 0, 1, 1, 1, 0);
    seg(2, 28, 29, 1, 0, 0, 0, 0, 1, 1, 0);
    seg(2, 30, 33, 1, 0, 0, 0, 1, 1, 0, 0);
    seg(2, 34, 35, 1, 0, 0, 0, 0, 1, 0, 0);
    seg(2, 36, 37, 1, 0, 0, 0, 0, 0, 0, 0);

    // set wins: clr_ovf together with the saturating event in cycle 14
    prefix(3);
    seg(3, 10, 10, 1, 0, 1, 0, 0, 0, 0, 0);
    seg(3, 11, 11, 1, 0, 1, 0, 0, 1, 1, 0);
    seg(3, 12, 12, 1, 0, 1, 0, 1, 1, 1, 0);
    seg(3, 13, 13, 1, 0, 1, 0, 1, 1, 2, 0);
    seg(3, 14, 14, 1, 0, 1, 1, 1, 1, 3, 0);
    seg(3, 15, 15, 1, 0, 0, 0, 1, 1, 3, 1);
    seg(3, 16, 17, 1, 0, 0, 0, 0, 1, 3, 1);

    // reset in cycle 14 during the first blink of a burst
    prefix(4);
    seg(4, 10, 10, 1, 0, 1, 0, 0, 0, 0, 0);
    seg(4, 11, 11, 1, 0, 1, 0, 0, 1, 1, 0);
    seg(4, 12, 12, 1, 0, 1, 0, 1, 1, 1, 0);
    seg(4, 13, 13, 1, 0, 0, 0, 1, 1, 2, 0);
    seg(4, 14, 14, 1, 1, 0, 0, 1, 1, 2, 0);
    seg(4, 15, 25, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int s = 0; s < 5; s++) begin
      int   rises;
      logic prev;
      rises = 0;
      prev  = 1'b0;
      foreach (vq[i]) begin
        if (vq[i].s == s) begin
          for (int c = vq[i].lo; c <= vq[i].hi; c++) begin
            drive(vq[i].rst, vq[i].din, vq[i].clr);
            if (vq[i].chk) begin
              check(names[s], c, {dout, busy, pending, ovf},
                    {vq[i].dout, vq[i].busy, vq[i].pend, vq[i].ovf});
              if (dout === 1'b1 && prev === 1'b0) rises++;
              prev = dout;
            end
            advance();
          end
        end
      end
      n_cmp++;
      if (rises != exp_blinks[s]) begin
        n_bad++;
        $display("FAIL %s blink count: got %0d required %0d", names[s], rises, exp_blinks[s]);
      end
    end

    // Event arriving in the RESET state is counted, then bounded wait for idle.
    begin
      int found;
      for (int k = 0; k < 3; k++) begin drive(1, 0, 0); advance(); end
      drive(0, 1, 0); advance();                                   // cycle 3
      drive(0, 0, 0);                                              // cycle 4
      check("rststate_q", 4, {dout, busy, pending, ovf}, {1'b0, 1'b1, 2'd1, 1'b0});
      advance();
      drive(0, 0, 0);                                              // cycle 5
      check("rststate_on", 5, {dout, busy, pending, ovf}, {1'b1, 1'b1, 2'd0, 1'b0});
      advance();
      found = -1;
      for (int k = 6; k < 50; k++) begin
        drive(0, 0, 0);
        if (busy === 1'b0) begin
          found = k;
          break;
        end
        advance();
      end
      n_cmp++;
      if (found != 11) begin
        n_bad++;
        $display("FAIL idle_wait: busy fell at cycle %0d required 11", found);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
